// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx -- I2S receiver, codec is bus master.
//
// bclk, lrclk and sdata are oversampled in the clk domain; no logic runs on
// BCLK itself. Each channel word is captured MSB first, left-justified into
// BITSIZE bits. Once both words of a frame are in, the block presents one
// stereo pair with a single-cycle valid strobe.
//
// Ports
//   clk        system clock, at least 4x BCLK
//   reset      synchronous, active-high
//   bclk       codec bit clock (asynchronous)
//   lrclk      codec ADC word clock, 0 = left, 1 = right (asynchronous)
//   sdata      codec ADC data, MSB first (asynchronous)
//   left_chan  last complete left sample
//   right_chan last complete right sample
//   valid      one-clk pulse when left_chan/right_chan take a new pair
// -----------------------------------------------------------------------------
module i2s_rx #(
  parameter int BITSIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid
);

  localparam int CW = $clog2(BITSIZE + 1);
  localparam logic [BITSIZE-1:0] MSB_ONE = {1'b1, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_e;

  state_e state_q, state_d;

  // Synchronisers; bclk gets a third stage for rising-edge detection.
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lr_s1_q, lr_s2_q;
  logic sd_s1_q, sd_s2_q;

  // Registered bit event with the lrclk/sdata values that belong to it.
  logic evt_q, evt_d;
  logic lr_q, lr_d;
  logic sd_q, sd_d;

  logic               lr_prev_q, lr_prev_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BITSIZE-1:0] shift_q, shift_d;
  logic [BITSIZE-1:0] hold_q, hold_d;
  logic [BITSIZE-1:0] left_q, left_d;
  logic [BITSIZE-1:0] right_q, right_d;
  logic               valid_q, valid_d;

  logic               boundary;
  logic               cnt_open;
  logic               take_bit;
  logic               complete;
  logic [BITSIZE-1:0] word;

  // ---------------------------------------------------------------------------
  // Bit-level datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    evt_d = bclk_s2_q & ~bclk_s3_q;
    lr_d  = lr_s2_q;
    sd_d  = sd_s2_q;

    boundary = evt_q && (lr_q != lr_prev_q);
    cnt_open = (cnt_q < CW'(BITSIZE));

    // The bit sampled on a boundary event is the LSB of the closing word
    // (one-BCLK I2S delay). An empty slot (count 0 at its boundary) is a
    // glitch and closes as an all-zero word.
    take_bit = evt_q && cnt_open && !(boundary && (cnt_q == '0));

    // Bits land left-justified, so a short word is zero-padded for free.
    word = shift_q;
    if (take_bit && sd_q) word = shift_q | (MSB_ONE >> cnt_q);

    // A boundary coinciding with the last counted bit is one completion.
    complete = evt_q && cnt_open && ((cnt_q == CW'(BITSIZE - 1)) || boundary);

    lr_prev_d = evt_q ? lr_q : lr_prev_q;

    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (boundary) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (take_bit) begin
      cnt_d   = cnt_q + CW'(1);
      shift_d = word;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // An empty slot drops back to SYNC so a one-BCLK lrclk glitch yields at most
  // one spurious pair before the receiver realigns on the next left boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (boundary && !lr_q) state_d = LEFT;
      LEFT:    if (boundary) state_d = (cnt_q == '0) ? SYNC : RIGHT;
      RIGHT:   if (boundary) state_d = (cnt_q == '0) ? SYNC : LEFT;
      default: state_d = SYNC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d  = hold_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
    if (complete) begin
      if (state_q == LEFT) begin
        hold_d = word;
      end else if (state_q == RIGHT) begin
        left_d  = hold_q;
        right_d = word;
        valid_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
      evt_q     <= 1'b0;
      lr_q      <= 1'b0;
      sd_q      <= 1'b0;
      lr_prev_q <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      bclk_s1_q <= bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lr_s1_q   <= lrclk;
      lr_s2_q   <= lr_s1_q;
      sd_s1_q   <= sdata;
      sd_s2_q   <= sd_s1_q;
      evt_q     <= evt_d;
      lr_q      <= lr_d;
      sd_q      <= sd_d;
      lr_prev_q <= lr_prev_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx -- self-checking bench for i2s_rx (BITSIZE = 16).
// An I2S codec model drives bclk = clk/16 with lrclk leading data by one BCLK.
// Expected pairs are queued as frames are sent and compared on each valid.
// -----------------------------------------------------------------------------
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        bclk, lrclk, sdata;
  logic [15:0] left_chan, right_chan;
  logic        valid;

  i2s_rx #(.BITSIZE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid      (valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          chk_lat;
    bit          chk_gap;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lsb_cyc = 0;
  int last_valid_cyc = 0;
  int lat;
  int spurious = 0;
  bit ignore_valid = 1'b0;
  bit valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (valid) begin
      check("valid_width", valid_prev, 0);
      if (ignore_valid) begin
        spurious++;
      end else if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("left_chan", left_chan, e.l);
        check("right_chan", right_chan, e.r);
        if (e.chk_lat) begin
          lat = cyc - lsb_cyc;
          if (lat < 4 || lat > 5) check("latency", lat, 4);
          else                    check("latency", lat, lat >= 4 && lat <= 5 ? lat : 4);
        end
        if (e.chk_gap) check("valid_gap", cyc - last_valid_cyc, 1024);
      end
      last_valid_cyc = cyc;
    end
    valid_prev = valid;
  end

  // One BCLK period: 8 clk low then 8 clk high; lrclk/sdata change on the fall.
  task automatic emit_bit(input logic lr, input logic d, input bit mark, input bit do_rst);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    repeat (8) @(negedge clk);
    bclk = 1'b1;
    if (mark) lsb_cyc = cyc;
    if (do_rst) begin
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_left", left_chan, 0);
      check("rst_right", right_chan, 0);
      check("rst_valid", valid, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  // One channel slot. lrclk for the last bit is already the next channel's.
  task automatic emit_slot(input logic ch, input logic [15:0] w, input int nbits,
                           input int slot, input logic [15:0] pad, input logic next_lr,
                           input int glitch_at, input int rst_at);
    logic lr, d;
    for (int j = 0; j < slot; j++) begin
      d  = (j < nbits) ? w[nbits-1-j] : pad[15-((j-nbits)%16)];
      lr = (j == slot - 1) ? next_lr : ((j == glitch_at) ? !ch : ch);
      emit_bit(lr, d, ch && (j == nbits - 1), j == rst_at);
    end
  endtask

  task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw, input int nbits,
                            input int slot, input logic [15:0] lpad, input logic [15:0] rpad,
                            input bit expect_it, input bit chk_lat, input bit chk_gap,
                            input int glitch_at, input int rst_at);
    exp_t x;
    if (expect_it) begin
      x.l = lw << (16 - nbits);
      x.r = rw << (16 - nbits);
      x.chk_lat = chk_lat;
      x.chk_gap = chk_gap;
      sb.push_back(x);
    end
    emit_slot(1'b0, lw, nbits, slot, lpad, 1'b1, glitch_at, rst_at);
    emit_slot(1'b1, rw, nbits, slot, rpad, 1'b0, -1, -1);
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_left", left_chan, 0);
    check("reset_right", right_chan, 0);
    check("reset_valid", valid, 0);
    reset = 1'b0;

    // Start in the right half: 0x1111 must not appear.
    emit_slot(1'b1, 16'h1111, 16, 32, 16'h0000, 1'b0, -1, -1);
    send_frame(16'h2222, 16'h3333, 16, 32, 16'h0000, 16'h0000, 1, 1, 0, -1, -1);

    // Nominal frame with non-zero slot padding.
    send_frame(16'h1234, 16'hABCD, 16, 32, 16'hFFFF, 16'h5555, 1, 1, 0, -1, -1);

    // Back-to-back frames, valid pulses 1024 clk apart.
    send_frame(16'h8000, 16'h7FFF, 16, 32, 16'h0000, 16'hFFFF, 1, 1, 1, -1, -1);
    send_frame(16'hFFFF, 16'h0001, 16, 32, 16'hAAAA, 16'h0000, 1, 1, 1, -1, -1);

    // Short 12-bit slots: zero-padded LSBs.
    send_frame(16'h0ABC, 16'h0123, 12, 12, 16'h0000, 16'h0000, 1, 0, 0, -1, -1);

    // Reset during left bit 7: frame discarded, next frame clean.
    send_frame(16'h5A5A, 16'hA5A5, 16, 32, 16'h0000, 16'h0000, 0, 0, 0, -1, 7);
    send_frame(16'h0F0F, 16'hF0F0, 16, 32, 16'h0000, 16'h0000, 1, 1, 0, -1, -1);

    // One-BCLK lrclk glitch mid-left slot, then a clean frame.
    ignore_valid = 1'b1;
    send_frame(16'h9999, 16'h6666, 16, 32, 16'h0000, 16'h0000, 0, 0, 0, 8, -1);
    ignore_valid = 1'b0;
    check("glitch_spurious_le1", spurious <= 1, 1);
    send_frame(16'h4444, 16'h5555, 16, 32, 16'h0000, 16'h0000, 1, 1, 0, -1, -1);

    waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("pairs_outstanding", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete within 60000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive side of the codec audio link: deserialises the ADCDAT stream from the codec into parallel left/right samples. The codec is bus master: it drives BCLK and ADCLRC, and this block only samples them. All three pins are sampled in one fast system clock domain, so no logic runs on BCLK. The block sits between the codec ADC pins and the DSP path (generators, multiplier, i2s_tx), and presents one stereo pair per frame with a single-cycle valid strobe.

## Interface
Parameters:
- BITSIZE, 16, sample width in bits.

Ports:
- clk  input  1  system clock. Must be at least 4× BCLK, with BCLK high and low each ≥ 2 clk periods; normally OSC at 49.152 MHz.
- reset  input  1  synchronous, active-high reset.
- bclk  input  1  codec bit clock, asynchronous to clk.
- lrclk  input  1  codec ADC word clock (ADCLRC), asynchronous; low = left, high = right.
- sdata  input  1  codec ADCDAT, asynchronous, MSB first.
- left_chan  output  BITSIZE  last complete left sample, two's complement as received.
- right_chan  output  BITSIZE  last complete right sample.
- valid  output  1  one-clk pulse when left_chan/right_chan are updated with a new pair.

One clock; reset is synchronous and active-high.

## Operation
- **Input synchronisers:** bclk, lrclk and sdata each pass through a 2-flop synchroniser. A third register on bclk detects a rising edge (sync=1, prev=0). All further logic acts only in clk cycles flagged as a BCLK rise ("bit event").
- **Word framing:** at each bit event, sample lrclk into lr_prev. A bit event where synced lrclk ≠ lr_prev is a word boundary. The bit sampled at the *next* bit event is the MSB of the new channel word (standard I2S one-BCLK delay).
- **Bit counter:** counts 0..BITSIZE and saturates at BITSIZE. The shift register takes sdata while count < BITSIZE. Bits beyond BITSIZE in a slot are ignored.
- **Word completion:** a channel word completes at whichever comes first:
  - count reaching BITSIZE, or
  - a word boundary arriving with count < BITSIZE. In this case the remaining LSBs are zero-padded (left-justified), and the word is completed at the boundary.
- **FSM states:**
  - SYNC: wait for a boundary to lrclk=0. Capture nothing.
  - LEFT: capture the left word into a holding register. On the boundary to lrclk=1, go to RIGHT.
  - RIGHT: capture the right word. On completion, load left_chan from the holding register and right_chan from the shift register, then pulse valid. On the boundary to lrclk=0, go to LEFT.
- **Partial right word:** if a right word is still incomplete at its closing boundary, it is padded and output at that boundary as above.
- **Boundary with no bits:** a boundary with count = 0 (lrclk glitch or a zero-length slot) still completes the word, as all zeros. The FSM remains consistent.
- **Reset:** left_chan=0, right_chan=0, valid=0, FSM=SYNC, counter=0, shift and holding registers=0, synchronisers=0.
  - A reset mid-frame discards the partial frame.
  - The first valid after reset follows the first complete left+right pair that starts after a left boundary.
- valid is never asserted while in SYNC. Outputs hold their value between valid pulses.

## Timing
- Latency: valid rises 4 or 5 clk cycles after the BCLK rising edge at the pin that carries right bit BITSIZE-1. The spread depends on the sampling phase: 2 synchroniser cycles, 1 edge-detect cycle, 1 register cycle, plus up to 1 cycle of phase uncertainty.
- left_chan and right_chan change in the same clk cycle that valid is high. They are stable for at least one frame afterwards.
- valid is exactly 1 clk wide, at most one pulse per LRCLK period.
- Simultaneous events: if count reaches BITSIZE on the same bit event as a boundary, completion and the boundary are processed together. There is exactly one completion, no double pulse, and the new word's counter restarts at 0.
- Minimum supported frame: 2 bit events per channel.

## Test plan
- **Nominal frame:** BITSIZE=16, clk 49.152 MHz, BCLK 3.072 MHz, 32-bit slots, left=0x1234 padded with 0xFFFF, right=0xABCD padded with 0x5555 → one valid pulse, left_chan=0x1234, right_chan=0xABCD, latency 4–5 clk from the right LSB BCLK rise.
- **Back-to-back frames:** (0x8000, 0x7FFF) then (0xFFFF, 0x0001) → two valid pulses exactly 1024 clk apart, each carrying its own pair, no cross-channel mixing.
- **Start in right half:** stream starts with lrclk high and right=0x1111, then a full frame (0x2222, 0x3333) → no valid for 0x1111; first valid shows 0x2222/0x3333.
- **Short slots:** 12-bit slots, left=0xABC, right=0x123 → left_chan=0xABC0, right_chan=0x1230.
- **Reset mid-frame:** reset asserted for 1 clk during left bit 7 → outputs read 0 from the next cycle. No valid for the interrupted frame; the next full frame (0x0F0F, 0xF0F0) is output correctly.
- **lrclk glitch:** lrclk toggles for one BCLK period in the middle of the left slot → no hang, at most one spurious zero-padded pair. The following frame (0x4444, 0x5555) is received correctly.
